// File: rtl/add_serial_seq.sv
// add_serial_seq: operand sequencer in front of the 8-bit serial adder.
// Buffers operand pairs in a 2-entry FIFO, issues one-cycle en pulses,
// samples out_sum LAT cycles after the pulse and returns it on a
// valid/ready result port.
// Optional build macro: ADD_SEQ_PRESCRAMBLE_EN (XOR a/b with A_MASK/B_MASK).
module add_serial_seq #(
    parameter int         LAT    = 10,
    parameter logic [7:0] A_MASK = 8'h32,
    parameter logic [7:0] B_MASK = 8'hD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       en,
    output logic [7:0] a,
    output logic [7:0] b,
    input  logic [7:0] out_sum,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

`ifdef ADD_SEQ_PRESCRAMBLE_EN
    localparam bit L_SCR = 1'b1;
`else
    localparam bit L_SCR = 1'b0;
`endif
    // Masks collapse to zero when pre-scrambling is not compiled in.
    localparam logic [7:0] L_A_MASK = L_SCR ? A_MASK : 8'h00;
    localparam logic [7:0] L_B_MASK = L_SCR ? B_MASK : 8'h00;
    localparam logic [7:0] L_WLOAD  = 8'(LAT - 1);

    state_t          r_state, w_next;
    logic [1:0][7:0] r_mem_a, r_mem_b;
    logic            r_wr, r_rd;
    logic [1:0]      r_cnt;
    logic [7:0]      r_wcnt;
    logic            r_en;
    logic [7:0]      r_a, r_b;
    logic            r_res_valid;
    logic [7:0]      r_res_data;

    logic            w_push, w_pop, w_load;
    logic [7:0]      w_a_ld, w_b_ld;

    assign in_ready  = (r_cnt != 2'd2);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_state == CAPTURE);
    assign w_load    = (r_state == IDLE) && (w_next == ISSUE);
    assign w_a_ld    = r_mem_a[r_rd] ^ L_A_MASK;
    assign w_b_ld    = r_mem_b[r_rd] ^ L_B_MASK;

    assign en        = r_en;
    assign a         = r_a;
    assign b         = r_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = (r_state != IDLE);

    // Next-state logic; IDLE holds off while a result is still unclaimed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_cnt != 2'd0 && !r_res_valid) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_wcnt == 8'd1) w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (rst)                    r_wcnt <= 8'd0;
        else if (r_state == ISSUE)  r_wcnt <= L_WLOAD;
        else if (r_state == WAIT)   r_wcnt <= r_wcnt - 8'd1;
    end

    // Operand FIFO: head stays put until CAPTURE so a/b can be reloaded from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_a <= '0;
            r_mem_b <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_cnt   <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr] <= in_a;
                r_mem_b[r_wr] <= in_b;
                r_wr          <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Adder drive: en registered for the ISSUE cycle, a/b latched on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= 1'b0;
            r_a  <= 8'h00;
            r_b  <= 8'h00;
        end else begin
            r_en <= (w_next == ISSUE);
            if (w_load) begin
                r_a <= w_a_ld;
                r_b <= w_b_ld;
            end
        end
    end

    // Result register: capture in CAPTURE, hold until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
        end else if (r_state == CAPTURE) begin
            r_res_valid <= 1'b1;
            r_res_data  <= out_sum;
        end else if (r_res_ready_take()) begin
            r_res_valid <= 1'b0;
        end
    end

    function automatic logic r_res_ready_take();
        return r_res_valid && res_ready;
    endfunction

endmodule

// File: tb/tb_add_serial_seq.sv
// tb_add_serial_seq: directed checks of the add_serial_seq sequencer with
// an adder stub that presents its result only on the sample cycle.
module tb_add_serial_seq;
    localparam int LAT = 10;

    logic       clk = 1'b0;
    logic       rst, in_valid, res_ready;
    logic [7:0] in_a, in_b, out_sum;
    logic       in_ready, en, res_valid, busy;
    logic [7:0] a, b, res_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cnt = 0;

    logic [7:0] sv [0:15];
    int         si  = 0;
    int         cd  = 0;
    logic [7:0] cur = 8'h00;

    add_serial_seq #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .en(en), .a(a), .b(b), .out_sum(out_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // cycle and en-pulse counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en) en_cnt <= en_cnt + 1;
    end

    // adder stub: out_sum carries the scripted value only in the sample cycle
    always @(posedge clk) begin
        if (rst) cd <= 0;
        else if (en) begin
            cd  <= LAT;
            cur <= sv[si];
            si  <= si + 1;
        end else if (cd > 0) cd <= cd - 1;
    end
    assign out_sum = (cd == 1) ? cur : 8'hEE;

    function automatic logic [7:0] xa(input logic [7:0] v);
`ifdef ADD_SEQ_PRESCRAMBLE_EN
        return v ^ 8'h32;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] xb(input logic [7:0] v);
`ifdef ADD_SEQ_PRESCRAMBLE_EN
        return v ^ 8'hD5;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // present a pair from the next negedge; returns after the accepting edge
    task automatic push(input logic [7:0] va, input logic [7:0] vb);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = va;
        in_b = vb;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        while (!en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("en_seen", en, 1);
    endtask

    task automatic take(input logic [7:0] exp);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", res_valid, 1);
        chk("res_data", res_data, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_clear", res_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, ec, e0, n;
        sv[0] = 8'h5A; sv[1] = 8'h77; sv[2] = 8'h11; sv[3] = 8'h22;
        sv[4] = 8'h33; sv[5] = 8'h99; sv[6] = 8'h44; sv[7] = 8'h55;
        sv[8] = 8'h66;
        for (int i = 9; i < 16; i++) sv[i] = 8'h00;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = 8'h00; in_b = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_a", a, 8'h00);
        chk("rst_b", b, 8'h00);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt", dut.r_cnt, 0);
        rst = 1'b0;
        e0 = en_cnt;
        repeat (50) @(negedge clk);
        chk("idle_no_en", en_cnt - e0, 0);
        chk("idle_busy", busy, 0);

        // single op with latency checks
        push(8'h12, 8'h34);
        p = cyc;
        drop_valid();
        wait_en();
        ec = cyc;
        e0 = en_cnt;
        chk("single_a", a, xa(8'h12));
        chk("single_b", b, xb(8'h34));
        chk("single_en_lat", ec - p, 1);
        @(negedge clk);
        chk("single_en_one", en, 0);
        chk("single_busy", busy, 1);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("single_rv_lat", cyc - ec, 11);
        take(8'h5A);
        chk("single_en_count", en_cnt - e0, 1);

        // zero operands: shows mask application (or raw pass-through)
        push(8'h00, 8'h00);
        drop_valid();
        wait_en();
        chk("mask_a", a, xa(8'h00));
        chk("mask_b", b, xb(8'h00));
        take(8'h77);

        // three back-to-back pairs with result back-pressure
        e0 = en_cnt;
        push(8'h01, 8'h02);
        push(8'h03, 8'h04);
        push(8'h05, 8'h06);
        drop_valid();
        chk("b2b_full", in_ready, 0);
        chk("b2b_rv_held", res_valid, 1);
        chk("b2b_first", res_data, 8'h11);
        repeat (30) @(negedge clk);
        chk("b2b_stall_en", en_cnt - e0, 1);
        chk("b2b_still_held", res_data, 8'h11);
        take(8'h11);
        take(8'h22);
        take(8'h33);
        chk("b2b_en_total", en_cnt - e0, 3);

        // reset while waiting on the adder
        push(8'h09, 8'h0A);
        drop_valid();
        wait_en();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'hFF;
        @(negedge clk);
        chk("wrst_en", en, 0);
        chk("wrst_rv", res_valid, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        e0 = en_cnt;
        chk("wrst_cnt", dut.r_cnt, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_in_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        chk("wrst_rv_stays", res_valid, 0);
        chk("wrst_no_en", en_cnt - e0, 0);
        push(8'h0B, 8'h0C);
        drop_valid();
        wait_en();
        chk("wrst_new_a", a, xa(8'h0B));
        chk("wrst_new_b", b, xb(8'h0C));
        take(8'h44);

        // push at cnt==1 coinciding with the CAPTURE pop
        push(8'h0D, 8'h0E);
        drop_valid();
        wait_en();
        repeat (LAT) @(negedge clk);
        chk("pp_pre_cnt", dut.r_cnt, 1);
        chk("pp_pre_rv", res_valid, 0);
        in_valid = 1'b1;
        in_a = 8'h0F;
        in_b = 8'h10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_cnt", dut.r_cnt, 1);
        chk("pp_rv", res_valid, 1);
        take(8'h55);
        wait_en();
        chk("pp_next_a", a, xa(8'h0F));
        chk("pp_next_b", b, xb(8'h10));
        take(8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
